ex_alu_stage: RTL

- Execute stage sitting directly downstream of the ALU control decoder; consumes its 5-bit ALU control code and Sign bit plus operands from ID/EX.
- Computes the ALU result and pushes result plus writeback tags into a small result queue, which forms the EX/MEM boundary.
- Provides a valid/ready handshake on both sides, a flush for branch/jump squash, and signed-overflow detection.

---
 rtl/ex_alu_stage.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/ex_alu_stage.sv
// rtl/ex_alu_stage.sv - execute-stage ALU feeding a DEPTH-entry EX/MEM result queue
// Optional build macro: EX_OVERFLOW_TRAP_EN (signed add/sub overflow suppresses writeback, flags out_ovf)
module ex_alu_stage #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_alu_ctrl,
    input  logic             in_sign,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [4:0]       in_shamt,
    input  logic [4:0]       in_rd,
    input  logic             in_reg_write,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic [4:0]       out_rd,
    output logic             out_reg_write,
    output logic             out_ovf
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] r_res [DEPTH];
    logic [4:0]       r_rd  [DEPTH];
    logic             r_rw  [DEPTH];
    logic             r_ovf [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;

    // Copy of the last visible head, so an empty queue keeps presenting stable fields.
    logic [WIDTH-1:0] r_last_res;
    logic [4:0]       r_last_rd;
    logic             r_last_rw;
    logic             r_last_ovf;

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic             w_lt;
    logic [WIDTH-1:0] w_res;
    logic             w_ovf;
    logic             w_rw;
    logic             w_push;
    logic             w_pop;
    logic             w_nonempty;
    logic [WIDTH-1:0] w_head_res;
    logic [4:0]       w_head_rd;
    logic             w_head_rw;
    logic             w_head_ovf;

    assign w_sum  = in_a + in_b;
    assign w_diff = in_a - in_b;
    assign w_lt   = in_sign ? ($signed(in_a) < $signed(in_b)) : (in_a < in_b);

    always_comb begin
        w_res = '0;
        case (in_alu_ctrl)
            5'd0:    w_res = w_sum;
            5'd1:    w_res = w_diff;
            5'd2:    w_res = in_a & in_b;
            5'd3:    w_res = in_a | in_b;
            5'd4:    w_res = in_a ^ in_b;
            5'd5:    w_res = ~(in_a | in_b);
            5'd6:    w_res = in_b << in_shamt;
            5'd7:    w_res = in_b >> in_shamt;
            5'd8:    w_res = $unsigned($signed(in_b) >>> in_shamt);
            5'd9:    w_res = {{(WIDTH-1){1'b0}}, w_lt};
            5'd10:   w_res = in_b;
            default: w_res = '0;
        endcase
    end

`ifdef EX_OVERFLOW_TRAP_EN
    assign w_ovf = in_sign &&
        (((in_alu_ctrl == 5'd0) && (in_a[WIDTH-1] == in_b[WIDTH-1]) && (w_sum[WIDTH-1]  != in_a[WIDTH-1])) ||
         ((in_alu_ctrl == 5'd1) && (in_a[WIDTH-1] != in_b[WIDTH-1]) && (w_diff[WIDTH-1] != in_a[WIDTH-1])));
    assign w_rw  = in_reg_write && !w_ovf;
`else
    assign w_ovf = 1'b0;
    assign w_rw  = in_reg_write;
`endif

    assign w_nonempty = (r_count != '0);
    assign in_ready   = (r_count != CW'(DEPTH));
    assign w_push     = in_valid && in_ready && !flush;
    assign w_pop      = w_nonempty && out_ready && !flush;

    assign w_head_res = w_nonempty ? r_res[r_rptr] : r_last_res;
    assign w_head_rd  = w_nonempty ? r_rd[r_rptr]  : r_last_rd;
    assign w_head_rw  = w_nonempty ? r_rw[r_rptr]  : r_last_rw;
    assign w_head_ovf = w_nonempty ? r_ovf[r_rptr] : r_last_ovf;

    assign out_valid     = w_nonempty;
    assign out_result    = w_head_res;
    assign out_zero      = (w_head_res == '0);
    assign out_rd        = w_head_rd;
    assign out_reg_write = w_head_rw;
    assign out_ovf       = w_head_ovf;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_res[i] <= '0;
                r_rd[i]  <= '0;
                r_rw[i]  <= 1'b0;
                r_ovf[i] <= 1'b0;
            end
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_last_res <= '0;
            r_last_rd  <= '0;
            r_last_rw  <= 1'b0;
            r_last_ovf <= 1'b0;
        end else begin
            r_last_res <= w_head_res;
            r_last_rd  <= w_head_rd;
            r_last_rw  <= w_head_rw;
            r_last_ovf <= w_head_ovf;
            if (flush) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) begin
                    r_res[r_wptr] <= w_res;
                    r_rd[r_wptr]  <= in_rd;
                    r_rw[r_wptr]  <= w_rw;
                    r_ovf[r_wptr] <= w_ovf;
                    r_wptr        <= r_wptr + 1'b1;
                end
                if (w_pop)
                    r_rptr <= r_rptr + 1'b1;
                if (w_push && !w_pop)
                    r_count <= r_count + 1'b1;
                else if (w_pop && !w_push)
                    r_count <= r_count - 1'b1;
            end
        end
    end
endmodule
